// File: rtl/result_scoreboard_pkg.sv
// Shared types and constants for the in-order result scoreboard.
package result_scoreboard_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } direction_t;

    typedef logic [WORD_SIZE-1:0] addr_t;
    typedef logic [WORD_SIZE-1:0] data_t;

    typedef struct packed {
        direction_t dir;
        addr_t      addr;
        data_t      data;
    } scb_item_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } scb_state_t;

    // Bit positions inside cmp_mask / err_field
    localparam int ERR_DATA = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_DIR  = 2;

endpackage

// File: rtl/result_scoreboard_fifo.sv
// Synchronous FIFO with wrap-bit pointers; buffers one side of the scoreboard.
module scb_fifo
    import result_scoreboard_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; the wrap bit distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/result_scoreboard.sv
// In-order expected/actual transaction scoreboard with masked field compare,
// saturating counters and halt-on-error. Optional stall watchdog is built
// when RESULT_SCB_TIMEOUT_EN is defined.
module result_scoreboard
    import result_scoreboard_pkg::*;
#(
    parameter int DATA_W  = WORD_SIZE,
    parameter int ADDR_W  = WORD_SIZE,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        exp_valid,
    output logic                        exp_ready,
    input  logic [ADDR_W+DATA_W:0]      exp_item,
    input  logic                        act_valid,
    output logic                        act_ready,
    input  logic [ADDR_W+DATA_W:0]      act_item,
    input  logic [2:0]                  cmp_mask,
    input  logic                        halt_on_err,
    output logic                        err_valid,
    output logic [2:0]                  err_field,
    output logic [ADDR_W+DATA_W:0]      err_exp,
    output logic [ADDR_W+DATA_W:0]      err_act,
    output logic [31:0]                 match_cnt,
    output logic [31:0]                 err_cnt,
    output logic [$clog2(DEPTH+1)-1:0]  pend_exp,
    output logic [$clog2(DEPTH+1)-1:0]  pend_act,
    output logic                        halted,
    output logic                        timeout
);

    localparam int IW = 1 + ADDR_W + DATA_W;

    scb_state_t      r_state;
    scb_state_t      w_state_nxt;
    logic            w_exp_full, w_exp_empty, w_act_full, w_act_empty;
    logic [IW-1:0]   w_exp_head, w_act_head;
    logic            w_pop;
    logic            r_vld_p1;
    logic [IW-1:0]   r_exp_p1, r_act_p1;
    logic [2:0]      w_diff;
    logic            w_commit, w_mismatch, w_halt_req, w_timeout;

    // Readies drop during reset and whenever the block is halted
    assign exp_ready = !rst && !w_exp_full && (r_state == RUN);
    assign act_ready = !rst && !w_act_full && (r_state == RUN);
    assign halted    = (r_state == HALT);
    assign timeout   = w_timeout;

    scb_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_exp_fifo (
        .clk(clk), .rst(rst), .push(exp_valid && exp_ready), .wdata(exp_item),
        .pop(w_pop), .rdata(w_exp_head), .full(w_exp_full), .empty(w_exp_empty),
        .count(pend_exp)
    );

    scb_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_act_fifo (
        .clk(clk), .rst(rst), .push(act_valid && act_ready), .wdata(act_item),
        .pop(w_pop), .rdata(w_act_head), .full(w_act_full), .empty(w_act_empty),
        .count(pend_act)
    );

    // Field comparison on the registered pair
    assign w_diff[ERR_DATA] = (r_exp_p1[DATA_W-1:0] != r_act_p1[DATA_W-1:0]) && cmp_mask[ERR_DATA];
    assign w_diff[ERR_ADDR] = (r_exp_p1[DATA_W +: ADDR_W] != r_act_p1[DATA_W +: ADDR_W]) && cmp_mask[ERR_ADDR];
    assign w_diff[ERR_DIR]  = (r_exp_p1[IW-1] != r_act_p1[IW-1]) && cmp_mask[ERR_DIR];

    assign w_commit   = r_vld_p1 && (r_state == RUN);
    assign w_mismatch = w_commit && (w_diff != 3'b000);
    assign w_halt_req = (w_mismatch && halt_on_err) || w_timeout;
    // No pop on the halting edge so the queues freeze with the unconsumed pair
    assign w_pop      = (r_state == RUN) && !w_exp_empty && !w_act_empty && !w_halt_req;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: HALT is only left through reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_halt_req) w_state_nxt = HALT;
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = RUN;
        endcase
    end

    // ---- stage p0 -> p1: popped pair registered for comparison ----
    always_ff @(posedge clk) begin
        if (rst) r_vld_p1 <= 1'b0;
        else     r_vld_p1 <= w_pop;
    end

    // Pair data register; qualified by r_vld_p1 so it carries no reset
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_exp_p1 <= w_exp_head;
            r_act_p1 <= w_act_head;
        end
    end

    // ---- stage p1 -> result: commit counters and error record ----
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_field <= '0;
            err_exp   <= '0;
            err_act   <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            err_valid <= w_mismatch;
            if (w_mismatch) begin
                err_field <= w_diff;
                err_exp   <= r_exp_p1;
                err_act   <= r_act_p1;
                if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
            end else if (w_commit && (match_cnt != 32'hFFFF_FFFF)) begin
                match_cnt <= match_cnt + 32'd1;
            end
        end
    end

`ifdef RESULT_SCB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;
    logic            w_one_side;

    assign w_one_side = (w_exp_empty != w_act_empty);
    assign w_timeout  = r_timeout;

    // Watchdog: counts RUN cycles with exactly one side waiting for a partner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == RUN) begin
            if (!w_one_side) begin
                r_wd_cnt <= '0;
            end else if (!r_timeout) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
                if (r_wd_cnt == WD_W'(TIMEOUT - 1)) r_timeout <= 1'b1;
            end
        end
    end
`else
    // Watchdog not built; a legal TIMEOUT (>= 1) makes this constant zero
    localparam logic WD_OFF = (TIMEOUT < 1);
    assign w_timeout = WD_OFF;
`endif

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed self-checking bench for result_scoreboard (DEPTH 8, TIMEOUT 16).
// Covers the watchdog when RESULT_SCB_TIMEOUT_EN is defined.
module tb_result_scoreboard;
    import result_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_valid = 1'b0, act_valid = 1'b0;
    logic        exp_ready, act_ready;
    scb_item_t   exp_item = '0, act_item = '0;
    logic [2:0]  cmp_mask = 3'b111;
    logic        halt_on_err = 1'b0;
    logic        err_valid;
    logic [2:0]  err_field;
    logic [64:0] err_exp, err_act;
    logic [31:0] match_cnt, err_cnt;
    logic [3:0]  pend_exp, pend_act;
    logic        halted, timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic saw_err;
    scb_item_t e1, a1, e2, a2;

    result_scoreboard #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_item(exp_item),
        .act_valid(act_valid), .act_ready(act_ready), .act_item(act_item),
        .cmp_mask(cmp_mask), .halt_on_err(halt_on_err),
        .err_valid(err_valid), .err_field(err_field),
        .err_exp(err_exp), .err_act(err_act),
        .match_cnt(match_cnt), .err_cnt(err_cnt),
        .pend_exp(pend_exp), .pend_act(pend_act),
        .halted(halted), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic scb_item_t mk(input direction_t d, input logic [31:0] a, input logic [31:0] v);
        scb_item_t it;
        it.dir  = d;
        it.addr = a;
        it.data = v;
        return it;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset
        tick(); tick();
        chk("rst_exp_ready", exp_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_exp_ready_after", exp_ready, 1);
        chk("rst_act_ready_after", act_ready, 1);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_pend_exp", pend_exp, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout", timeout, 0);

        // Eight identical pairs streamed back to back
        saw_err = 1'b0;
        exp_valid = 1'b1; act_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_item = mk(WRITE, 32'h100 + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
            act_item = exp_item;
            tick();
            if (err_valid !== 1'b0) saw_err = 1'b1;
        end
        exp_valid = 1'b0; act_valid = 1'b0;
        repeat (3) begin
            tick();
            if (err_valid !== 1'b0) saw_err = 1'b1;
        end
        chk("stream_match_cnt", match_cnt, 8);
        chk("stream_err_cnt", err_cnt, 0);
        chk("stream_no_err_valid", saw_err, 0);
        chk("stream_pend_act", pend_act, 0);

        // Data mismatch, no halt: pulse exactly two edges after the push
        e1 = mk(WRITE, 32'h300, 32'h1234);
        a1 = mk(WRITE, 32'h300, 32'h1235);
        exp_item = e1; act_item = a1; exp_valid = 1'b1; act_valid = 1'b1;
        tick();
        exp_valid = 1'b0; act_valid = 1'b0;
        tick();
        chk("data_err_n1", err_valid, 0);
        tick();
        chk("data_err_n2", err_valid, 1);
        chk("data_err_field", err_field, 3'b001);
        chk("data_err_cnt", err_cnt, 1);
        chk("data_err_exp", err_exp, e1);
        chk("data_err_act", err_act, a1);
        tick();
        chk("data_err_pulse_end", err_valid, 0);
        exp_item = e1; act_item = e1; exp_valid = 1'b1; act_valid = 1'b1;
        tick();
        exp_valid = 1'b0; act_valid = 1'b0;
        repeat (3) tick();
        chk("continue_match_cnt", match_cnt, 9);
        chk("continue_halted", halted, 0);

        // Same data mismatch with data compare masked off
        cmp_mask = 3'b110;
        saw_err = 1'b0;
        exp_item = e1; act_item = a1; exp_valid = 1'b1; act_valid = 1'b1;
        tick();
        exp_valid = 1'b0; act_valid = 1'b0;
        repeat (3) begin
            tick();
            if (err_valid !== 1'b0) saw_err = 1'b1;
        end
        chk("mask_match_cnt", match_cnt, 10);
        chk("mask_err_cnt", err_cnt, 1);
        chk("mask_no_err_valid", saw_err, 0);
        chk("mask_err_field_held", err_field, 3'b001);

        // Back-to-back mismatches give consecutive pulses
        cmp_mask = 3'b111;
        e2 = mk(READ, 32'h310, 32'h2);
        a2 = mk(READ, 32'h310, 32'h3);
        exp_item = e1; act_item = a1; exp_valid = 1'b1; act_valid = 1'b1;
        tick();
        exp_item = e2; act_item = a2;
        tick();
        exp_valid = 1'b0; act_valid = 1'b0;
        tick();
        chk("b2b_first_valid", err_valid, 1);
        chk("b2b_first_exp", err_exp, e1);
        tick();
        chk("b2b_second_valid", err_valid, 1);
        chk("b2b_second_act", err_act, a2);
        chk("b2b_err_cnt", err_cnt, 3);
        tick();
        chk("b2b_pulse_end", err_valid, 0);

        // Address and direction mismatch with halt_on_err
        halt_on_err = 1'b1;
        e1 = mk(WRITE, 32'h200, 32'h55);
        a1 = mk(READ,  32'h204, 32'h55);
        exp_item = e1; act_item = a1; exp_valid = 1'b1; act_valid = 1'b1;
        tick();
        exp_valid = 1'b0; act_valid = 1'b0;
        tick(); tick();
        chk("halt_err_valid", err_valid, 1);
        chk("halt_err_field", err_field, 3'b110);
        chk("halt_halted", halted, 1);
        chk("halt_exp_ready", exp_ready, 0);
        chk("halt_act_ready", act_ready, 0);
        chk("halt_err_cnt", err_cnt, 4);
        exp_item = e1; exp_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
        chk("halt_err_valid_drop", err_valid, 0);
        chk("halt_no_push", pend_exp, 0);
        chk("halt_match_frozen", match_cnt, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        halt_on_err = 1'b0;
        #1;
        chk("rst2_match_cnt", match_cnt, 0);
        chk("rst2_err_cnt", err_cnt, 0);
        chk("rst2_pend_exp", pend_exp, 0);
        chk("rst2_pend_act", pend_act, 0);
        chk("rst2_exp_ready", exp_ready, 1);
        chk("rst2_act_ready", act_ready, 1);
        chk("rst2_halted", halted, 0);
        chk("rst2_err_field", err_field, 0);
        chk("rst2_err_exp", err_exp, 0);

        // Fill the expected FIFO, refuse a ninth push, then drain with actuals
        exp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_item = mk(READ, 32'h400 + 32'(4 * i), 32'(i));
            tick();
        end
        chk("full_pend_exp", pend_exp, 8);
        chk("full_exp_ready", exp_ready, 0);
        chk("full_act_ready", act_ready, 1);
        exp_item = mk(READ, 32'hDEAD, 32'hBEEF);
        tick();
        exp_valid = 1'b0;
        chk("full_ninth_refused", pend_exp, 8);
        act_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            act_item = mk(READ, 32'h400 + 32'(4 * i), 32'(i));
            tick();
        end
        act_valid = 1'b0;
        repeat (3) tick();
        chk("drain_match_cnt", match_cnt, 8);
        chk("drain_err_cnt", err_cnt, 0);
        chk("drain_pend_exp", pend_exp, 0);
        chk("drain_pend_act", pend_act, 0);

        // Lone expected item
        exp_item = mk(WRITE, 32'h500, 32'h77); exp_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
`ifdef RESULT_SCB_TIMEOUT_EN
        repeat (15) tick();
        chk("wd_not_yet", timeout, 0);
        tick();
        chk("wd_timeout", timeout, 1);
        chk("wd_halted_lag", halted, 0);
        tick();
        chk("wd_halted", halted, 1);
        chk("wd_exp_ready", exp_ready, 0);
`else
        repeat (20) tick();
        chk("nowd_timeout", timeout, 0);
        chk("nowd_halted", halted, 0);
        chk("nowd_pend_exp", pend_exp, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
